matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameters WORD_SIZE (default 32, buffer word width) and DATA_SIZE (default from shared define, buffer index width).
REQ-002 SHALL have port clk, input, 1 bit, clock for all state.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have ports cfg_valid (in, 1), cfg_m/cfg_k/cfg_n (in, 4 each), and cfg_ready (out, 1) forming the dimension handshake.
REQ-005 SHALL have ports s_valid (in, 1), s_data (in, 8), and s_ready (out, 1) forming the element stream, one signed-agnostic byte per beat.
REQ-006 SHALL have ports wr_en_a (out, 1), index_a (out, DATA_SIZE), and data_a (out, WORD_SIZE) as the A-buffer write port.
REQ-007 SHALL have ports wr_en_b (out, 1), index_b (out, DATA_SIZE), and data_b (out, WORD_SIZE) as the B-buffer write port.
REQ-008 SHALL have ports tpu_start (out, 1), tpu_m/tpu_k/tpu_n (out, 4 each), and tpu_done (in, 1) toward the systolic core.
REQ-009 SHALL have ports busy (out, 1) and err (out, 1 cycle pulse) for a zero-dimension config.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, START, WAIT_DONE.
- IDLE to LOAD_A: on cfg handshake.
- LOAD_A to LOAD_B: after last A word is written.
- LOAD_B to START: after last B word is written.
- START to WAIT_DONE: unconditionally.
- WAIT_DONE to IDLE: when tpu_done=1.
REQ-011 SHALL assert cfg_ready only in IDLE, and latch m, k, n on cfg_valid&cfg_ready; tpu_m/k/n SHALL hold the latched values until the next accepted config.
REQ-012 SHALL, on an accepted config with any dimension 0, pulse err for one cycle, stay in IDLE, and produce no writes and no start.
REQ-013 SHALL assert s_ready exactly in LOAD_A and LOAD_B; a beat is accepted on s_valid&s_ready.
REQ-014 SHALL load A in stream order: row-tile t (0..ceil(m/4)-1), then column kk (0..k-1), then lane r (0..min(4,m-4t)-1), element A[4t+r][kk].
REQ-015 SHALL load B in stream order: column-tile t (0..ceil(n/4)-1), then row kk (0..k-1), then lane c (0..min(4,n-4t)-1), element B[kk][4t+c].
REQ-016 SHALL place lane 0 in bits [31:24], lane 1 in [23:16], lane 2 in [15:8], and lane 3 in [7:0]; lanes beyond the valid count SHALL be zero (padding inserted without host beats).
REQ-017 SHALL write word address t*k+kk; the write SHALL occur with wr_en one cycle after the beat completing the group, with index/data valid in that same cycle; wr_en SHALL be high exactly one cycle per word.
REQ-018 SHALL compute word address with an incrementing counter (no multiplier); the counter SHALL reset to 0 at entry to LOAD_A and LOAD_B.
REQ-019 SHALL keep index/data outputs at their last value when wr_en=0; wr_en_a and wr_en_b SHALL never both be high.
REQ-020 SHALL write the last A word in the first LOAD_B cycle, permitting a B beat to be accepted in that same cycle.
REQ-021 SHALL pulse tpu_start for exactly one cycle in START, after the last B write has completed.
REQ-022 SHALL hold busy=1 in every state except IDLE.
REQ-023 SHALL ignore tpu_done outside WAIT_DONE and ignore s_valid in IDLE/START/WAIT_DONE.
REQ-024 SHALL produce total word counts of ceil(m/4)*k for A and ceil(n/4)*k for B; for dimension 15 the maximum is 60 words, which fits the address width.

Reset
REQ-025 SHALL on rst force state IDLE and drive all outputs to 0, including cfg_ready=0 during rst and cfg_ready=1 after release.
REQ-026 SHALL on rst mid-load discard the partial word and generate no write.
REQ-027 SHALL on rst in WAIT_DONE generate no further start.

Structure
REQ-028 SHALL take WORD_SIZE, DATA_SIZE, and the FSM state encoding constants from the shared define file.
REQ-029 SHALL use one sub-module lane_packer (byte-to-word packer with lane counter, zero fill, and word-complete strobe), instantiated once and shared by the A and B phases.

Verification
REQ-030 SHALL cover: m=k=n=4, A bytes 1..16, B bytes 17..32 -> 4 A writes then 4 B writes, data_a@0=0x01020304, data_b@3=0x1D1E1F20, one tpu_start.
REQ-031 SHALL cover: m=5, k=2, n=1 -> A words 0..3, word 2=0xXX000000 (lane 0 only), B words 0..1 with lanes 1..3 zero.
REQ-032 SHALL cover: cfg_k=0 -> err pulse, no wr_en, no tpu_start, busy stays 0.
REQ-033 SHALL cover: random s_valid gaps (50%) with m=k=n=15 -> 60 A and 60 B writes, contents match a reference packing.
REQ-034 SHALL cover: rst asserted after 3 beats of a 4-lane group -> no write; a fresh config then loads correctly.
REQ-035 SHALL cover: tpu_done held high before WAIT_DONE -> ignored; start occurs once; return to IDLE on the next done.

Source files
------------

// File: rtl/matrix_loader_pkg.sv
// Shared constants and types for the matrix loader: buffer widths, dimension width
// and the controller state encoding.
package matrix_loader_pkg;

   localparam int DEF_WORD_SIZE = 32;
   localparam int DEF_DATA_SIZE = 6;
   localparam int DIM_W         = 4;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_A    = 3'd1,
      LOAD_B    = 3'd2,
      START     = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   // Number of real lanes in a tile given the rows/columns still to be covered.
   function automatic logic [2:0] lanes_in_tile(input logic [DIM_W-1:0] remaining);
      return (remaining >= 4'd4) ? 3'd4 : remaining[2:0];
   endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Bundle of the loader's handshake, stream, buffer-write and systolic-core signals.
// The loader connects to the master view, its environment to the slave view.
interface matrix_loader_if
#(
   parameter int WORD_SIZE = matrix_loader_pkg::DEF_WORD_SIZE,
   parameter int DATA_SIZE = matrix_loader_pkg::DEF_DATA_SIZE
) ();

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [3:0]            cfg_m;
   logic [3:0]            cfg_k;
   logic [3:0]            cfg_n;

   logic                  s_valid;
   logic                  s_ready;
   logic [7:0]            s_data;

   logic                  wr_en_a;
   logic [DATA_SIZE-1:0]  index_a;
   logic [WORD_SIZE-1:0]  data_a;
   logic                  wr_en_b;
   logic [DATA_SIZE-1:0]  index_b;
   logic [WORD_SIZE-1:0]  data_b;

   logic                  tpu_start;
   logic [3:0]            tpu_m;
   logic [3:0]            tpu_k;
   logic [3:0]            tpu_n;
   logic                  tpu_done;

   logic                  busy;
   logic                  err;

   modport master (
      input  cfg_valid, cfg_m, cfg_k, cfg_n, s_valid, s_data, tpu_done,
      output cfg_ready, s_ready,
      output wr_en_a, index_a, data_a, wr_en_b, index_b, data_b,
      output tpu_start, tpu_m, tpu_k, tpu_n, busy, err
   );

   modport slave (
      output cfg_valid, cfg_m, cfg_k, cfg_n, s_valid, s_data, tpu_done,
      input  cfg_ready, s_ready,
      input  wr_en_a, index_a, data_a, wr_en_b, index_b, data_b,
      input  tpu_start, tpu_m, tpu_k, tpu_n, busy, err
   );

endinterface

// File: rtl/matrix_loader_lane_packer.sv
// Packs up to four stream bytes into one word, lane 0 in the top byte; unfilled lanes
// stay zero. word/word_done present the completed word in the cycle of its final beat.
module lane_packer
   import matrix_loader_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 beat,
   input  logic [7:0]           byte_in,
   input  logic [2:0]           lane_count,
   output logic [WORD_SIZE-1:0] word,
   output logic                 word_done
);

   logic [1:0]  lane;
   logic [31:0] acc;
   logic [31:0] merged;

   always_comb begin
      merged = acc;
      if (beat) begin
         case (lane)
            2'd0:    merged[31:24] = byte_in;
            2'd1:    merged[23:16] = byte_in;
            2'd2:    merged[15:8]  = byte_in;
            default: merged[7:0]   = byte_in;
         endcase
      end
   end

   assign word      = WORD_SIZE'(merged);
   assign word_done = beat && (({1'b0, lane} + 3'd1) == lane_count);

   // The accumulator empties as soon as a word completes, so the next group starts zero-filled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         lane <= '0;
      end else if (clear) begin
         acc  <= '0;
         lane <= '0;
      end else if (beat) begin
         if (word_done) begin
            acc  <= '0;
            lane <= '0;
         end else begin
            acc  <= merged;
            lane <= lane + 2'd1;
         end
      end
   end

endmodule

// File: rtl/matrix_loader.sv
// Streams A and B operand bytes into lane-packed buffer words for the systolic core,
// then starts the core and waits for it to finish.
module matrix_loader
   import matrix_loader_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int DATA_SIZE = DEF_DATA_SIZE
) (
   input  logic           clk,
   input  logic           rst,
   matrix_loader_if.master bus
);

   state_t state, next_state;

   logic [3:0]            dim_m, dim_k, dim_n;
   logic [3:0]            kk;
   logic [3:0]            rem;
   logic [DATA_SIZE-1:0]  addr;
   logic                  last_pending;

   logic                  wr_en_a_q, wr_en_b_q, err_q;
   logic [DATA_SIZE-1:0]  index_a_q, index_b_q;
   logic [WORD_SIZE-1:0]  data_a_q, data_b_q;

   logic                  cfg_ready_c, s_ready_c, busy_c, start_c, load_active;
   logic                  cfg_accept, cfg_zero, beat;
   logic                  word_done, last_col, last_tile, last_word;
   logic [WORD_SIZE-1:0]  packed_word;

   assign cfg_accept = bus.cfg_valid && cfg_ready_c;
   assign cfg_zero   = (bus.cfg_m == 4'd0) || (bus.cfg_k == 4'd0) || (bus.cfg_n == 4'd0);
   assign beat       = bus.s_valid && s_ready_c && !last_pending;
   assign last_col   = (kk == dim_k - 4'd1);
   assign last_tile  = (rem <= 4'd4);
   assign last_word  = word_done && last_col && last_tile;

   lane_packer #(.WORD_SIZE(WORD_SIZE)) packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (!load_active),
      .beat       (beat),
      .byte_in    (bus.s_data),
      .lane_count (lanes_in_tile(rem)),
      .word       (packed_word),
      .word_done  (word_done)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic; B hands over to START only once its final word is on the bus.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (cfg_accept && !cfg_zero) next_state = LOAD_A;
         LOAD_A:    if (last_word) next_state = LOAD_B;
         LOAD_B:    if (last_pending) next_state = START;
         START:     next_state = WAIT_DONE;
         WAIT_DONE: if (bus.tpu_done) next_state = IDLE;
         default:   next_state = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      cfg_ready_c = 1'b0;
      s_ready_c   = 1'b0;
      busy_c      = 1'b1;
      start_c     = 1'b0;
      load_active = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready_c = !rst;
            busy_c      = 1'b0;
         end
         LOAD_A, LOAD_B: begin
            s_ready_c   = 1'b1;
            load_active = 1'b1;
         end
         START:   start_c = 1'b1;
         default: ;
      endcase
   end

   // Tile walk: addr steps once per word; rem counts rows/columns left, dropping by four per tile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dim_m        <= '0;
         dim_k        <= '0;
         dim_n        <= '0;
         kk           <= '0;
         rem          <= '0;
         addr         <= '0;
         last_pending <= 1'b0;
         err_q        <= 1'b0;
         wr_en_a_q    <= 1'b0;
         wr_en_b_q    <= 1'b0;
         index_a_q    <= '0;
         index_b_q    <= '0;
         data_a_q     <= '0;
         data_b_q     <= '0;
      end else begin
         err_q     <= 1'b0;
         wr_en_a_q <= 1'b0;
         wr_en_b_q <= 1'b0;
         if (cfg_accept) begin
            dim_m        <= bus.cfg_m;
            dim_k        <= bus.cfg_k;
            dim_n        <= bus.cfg_n;
            err_q        <= cfg_zero;
            addr         <= '0;
            kk           <= '0;
            rem          <= bus.cfg_m;
            last_pending <= 1'b0;
         end
         if (word_done) begin
            if (state == LOAD_A) begin
               wr_en_a_q <= 1'b1;
               index_a_q <= addr;
               data_a_q  <= packed_word;
            end else begin
               wr_en_b_q <= 1'b1;
               index_b_q <= addr;
               data_b_q  <= packed_word;
            end
            if (last_word) begin
               addr <= '0;
               kk   <= '0;
               rem  <= dim_n;
               if (state == LOAD_B) last_pending <= 1'b1;
            end else begin
               addr <= addr + DATA_SIZE'(1);
               if (last_col) begin
                  kk  <= '0;
                  rem <= rem - 4'd4;
               end else begin
                  kk  <= kk + 4'd1;
               end
            end
         end
         if ((state == LOAD_B) && last_pending) last_pending <= 1'b0;
      end
   end

   assign bus.cfg_ready = cfg_ready_c;
   assign bus.s_ready   = s_ready_c;
   assign bus.busy      = busy_c;
   assign bus.tpu_start = start_c;
   assign bus.err       = err_q;
   assign bus.tpu_m     = dim_m;
   assign bus.tpu_k     = dim_k;
   assign bus.tpu_n     = dim_n;
   assign bus.wr_en_a   = wr_en_a_q;
   assign bus.index_a   = index_a_q;
   assign bus.data_a    = data_a_q;
   assign bus.wr_en_b   = wr_en_b_q;
   assign bus.index_b   = index_b_q;
   assign bus.data_b    = data_b_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: a reference packer fills write scoreboards that a
// negedge monitor drains as the loader writes its A and B buffers.
module tb_matrix_loader;
   import matrix_loader_pkg::*;

   typedef struct {
      int          idx;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   matrix_loader_if bus ();

   matrix_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          n_wr_a   = 0;
   int          n_wr_b   = 0;
   int          n_start  = 0;
   int          n_err    = 0;
   wr_t         exp_a[$];
   wr_t         exp_b[$];
   logic [7:0]  stream_q[$];
   logic [7:0]  mat_a [15][15];
   logic [7:0]  mat_b [15][15];
   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_assert++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Buffer-write monitor: every write must match the head of its scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (!rst) begin
         if (bus.wr_en_a || bus.wr_en_b)
            check_output("wr_exclusive", 32'(bus.wr_en_a & bus.wr_en_b), 32'd0);
         if (bus.wr_en_a) begin
            check_output("wr_a_expected", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) begin
               e = exp_a.pop_front();
               check_output("index_a", 32'(bus.index_a), 32'(e.idx));
               check_output("data_a", bus.data_a, e.data);
            end
            mem_a[bus.index_a] = bus.data_a;
            n_wr_a++;
         end
         if (bus.wr_en_b) begin
            check_output("wr_b_expected", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) begin
               e = exp_b.pop_front();
               check_output("index_b", 32'(bus.index_b), 32'(e.idx));
               check_output("data_b", bus.data_b, e.data);
            end
            mem_b[bus.index_b] = bus.data_b;
            n_wr_b++;
         end
         if (bus.tpu_start) begin
            check_output("start_after_b", 32'(exp_b.size()), 32'd0);
            n_start++;
         end
         if (bus.err) n_err++;
      end
   end

   task automatic build_job(input int m, input int k, input int n, input bit directed);
      logic [31:0] w;
      stream_q.delete();
      for (int i = 0; i < 15; i++)
         for (int j = 0; j < 15; j++) begin
            mat_a[i][j] = directed ? 8'(1 + 4*j + i)  : 8'($urandom_range(255, 0));
            mat_b[i][j] = directed ? 8'(17 + 4*i + j) : 8'($urandom_range(255, 0));
         end
      for (int t = 0; t < (m + 3) / 4; t++)
         for (int kk = 0; kk < k; kk++) begin
            w = '0;
            for (int r = 0; r < 4; r++)
               if (4*t + r < m) begin
                  w[31 - 8*r -: 8] = mat_a[4*t + r][kk];
                  stream_q.push_back(mat_a[4*t + r][kk]);
               end
            exp_a.push_back('{t*k + kk, w});
         end
      for (int t = 0; t < (n + 3) / 4; t++)
         for (int kk = 0; kk < k; kk++) begin
            w = '0;
            for (int c = 0; c < 4; c++)
               if (4*t + c < n) begin
                  w[31 - 8*c -: 8] = mat_b[kk][4*t + c];
                  stream_q.push_back(mat_b[kk][4*t + c]);
               end
            exp_b.push_back('{t*k + kk, w});
         end
   endtask

   task automatic send_cfg(input logic [3:0] m, input logic [3:0] k, input logic [3:0] n);
      int guard = 0;
      @(negedge clk);
      bus.cfg_valid = 1'b1;
      bus.cfg_m     = m;
      bus.cfg_k     = k;
      bus.cfg_n     = n;
      while (!bus.cfg_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check_output("cfg_ready_seen", 32'(bus.cfg_ready), 32'd1);
      @(negedge clk);
      bus.cfg_valid = 1'b0;
   endtask

   // Drives the byte stream, optionally idling s_valid on about half the cycles.
   task automatic apply_stimulus(input bit gaps);
      int guard = 0;
      bit take;
      while (stream_q.size() > 0 && guard < 5000) begin
         @(negedge clk);
         guard++;
         if (gaps && ($urandom_range(1, 0) == 0)) begin
            bus.s_valid = 1'b0;
         end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = stream_q[0];
         end
         take = bus.s_valid && bus.s_ready;
         @(posedge clk);
         if (take) void'(stream_q.pop_front());
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      check_output("stream_drained", 32'(stream_q.size()), 32'd0);
   endtask

   task automatic run_job(input int m, input int k, input int n,
                          input bit directed, input bit gaps, input bit pulse_done);
      int s0 = n_start;
      int a0 = n_wr_a;
      int b0 = n_wr_b;
      int guard = 0;
      build_job(m, k, n, directed);
      send_cfg(4'(m), 4'(k), 4'(n));
      check_output("busy_after_cfg", 32'(bus.busy), 32'd1);
      apply_stimulus(gaps);
      while (n_start == s0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_output("start_seen", 32'(n_start - s0), 32'd1);
      check_output("tpu_dims", {20'd0, bus.tpu_m, bus.tpu_k, bus.tpu_n}, 32'(m*256 + k*16 + n));
      check_output("wr_a_count", 32'(n_wr_a - a0), 32'(((m + 3) / 4) * k));
      check_output("wr_b_count", 32'(n_wr_b - b0), 32'(((n + 3) / 4) * k));
      if (pulse_done) begin
         @(negedge clk);
         check_output("busy_wait_done", 32'(bus.busy), 32'd1);
         bus.tpu_done = 1'b1;
         @(negedge clk);
         bus.tpu_done = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_output("busy_idle", 32'(bus.busy), 32'd0);
      check_output("single_start", 32'(n_start - s0), 32'd1);
   endtask

   initial begin
      int a0, b0, s0, e0;
      bus.cfg_valid = 1'b0;
      bus.cfg_m     = '0;
      bus.cfg_k     = '0;
      bus.cfg_n     = '0;
      bus.s_valid   = 1'b0;
      bus.s_data    = '0;
      bus.tpu_done  = 1'b0;
      #2 rst = 1'b1;

      // Reset values
      @(negedge clk);
      check_output("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      check_output("rst_busy", 32'(bus.busy), 32'd0);
      check_output("rst_wr_en", 32'({bus.wr_en_a, bus.wr_en_b}), 32'd0);
      check_output("rst_start_err", 32'({bus.tpu_start, bus.err}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_output("cfg_ready_after_rst", 32'(bus.cfg_ready), 32'd1);

      $display("[TB] square 4x4x4 directed load");
      run_job(4, 4, 4, 1'b1, 1'b0, 1'b1);
      check_output("data_a_word0", mem_a[0], 32'h01020304);
      check_output("data_b_word3", mem_b[3], 32'h1D1E1F20);

      $display("[TB] ragged m=5 k=2 n=1");
      run_job(5, 2, 1, 1'b0, 1'b0, 1'b1);
      check_output("a_word2_pad", 32'(mem_a[2][23:0]), 32'd0);
      check_output("b_word0_pad", 32'(mem_b[0][23:0]), 32'd0);
      check_output("b_word1_pad", 32'(mem_b[1][23:0]), 32'd0);

      $display("[TB] zero dimension config");
      a0 = n_wr_a; b0 = n_wr_b; s0 = n_start; e0 = n_err;
      send_cfg(4'd4, 4'd0, 4'd4);
      check_output("err_pulse", 32'(bus.err), 32'd1);
      check_output("busy_zero_cfg", 32'(bus.busy), 32'd0);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hAA;
      @(negedge clk);
      check_output("err_one_cycle", 32'(bus.err), 32'd0);
      check_output("s_ready_idle", 32'(bus.s_ready), 32'd0);
      repeat (10) @(negedge clk);
      bus.s_valid = 1'b0;
      check_output("zero_cfg_busy", 32'(bus.busy), 32'd0);
      check_output("zero_cfg_err_count", 32'(n_err - e0), 32'd1);
      check_output("zero_cfg_writes", 32'((n_wr_a - a0) + (n_wr_b - b0)), 32'd0);
      check_output("zero_cfg_start", 32'(n_start - s0), 32'd0);

      $display("[TB] 15x15x15 with stream gaps");
      run_job(15, 15, 15, 1'b0, 1'b1, 1'b1);

      $display("[TB] reset during partial group");
      a0 = n_wr_a;
      send_cfg(4'd4, 4'd1, 4'd4);
      check_output("s_ready_load_a", 32'(bus.s_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(8'hC0 + i);
      end
      @(negedge clk);
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_output("partial_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
      check_output("mid_rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_output("partial_no_write", 32'(n_wr_a - a0), 32'd0);
      check_output("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      run_job(4, 1, 4, 1'b0, 1'b0, 1'b1);

      $display("[TB] tpu_done held high before WAIT_DONE");
      bus.tpu_done = 1'b1;
      repeat (3) @(negedge clk);
      run_job(6, 3, 7, 1'b0, 1'b1, 1'b0);
      bus.tpu_done = 1'b0;
      repeat (3) @(negedge clk);
      check_output("done_held_cfg_ready", 32'(bus.cfg_ready), 32'd1);
      check_output("scoreboards_empty", 32'(exp_a.size() + exp_b.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
